load_store_unit: RTL and testbench

- Initiator side of the data-memory interface. Accepts one load/store request at a time from the execute stage, using the RV32 funct3 size/sign encoding (dmctrl).
- Drives a word-organised memory port with byte enables. Splits misaligned accesses into two word beats.
- Merges, aligns and sign/zero-extends read data, then returns a single response to the core.
- Sits between the pipeline MEM stage and the data memory.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_load_align.sv | 25 ++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: dmctrl size/sign codes, FSM states,
// and helpers that turn dmctrl plus byte offset into lane masks and crossing flags.
package lsu_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE0,
        ST_WAIT0,
        ST_ISSUE1,
        ST_WAIT1,
        ST_RESP
    } lsu_state_t;

    function automatic logic [3:0] size_mask(input logic [2:0] dmctrl);
        case (dmctrl[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [2:0] dmctrl);
        case (dmctrl[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic dmctrl_illegal(input logic [2:0] dmctrl);
        return (dmctrl[1:0] == 2'b11) || (dmctrl == 3'b110);
    endfunction

    function automatic logic crosses_word(input logic [1:0] off, input logic [2:0] dmctrl);
        return ({1'b0, off} + size_bytes(dmctrl)) > 3'd4;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load return path: shifts the two-beat read window down by the byte
// offset, truncates to the access size and sign- or zero-extends. No state, no latency.
module lsu_load_align (
    input  logic [31:0] i_rdata1,
    input  logic [31:0] i_rdata0,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_dmctrl,
    output logic [31:0] o_rdata
);

    logic [31:0] w_raw;
    logic        w_sext;

    assign w_raw  = 32'({i_rdata1, i_rdata0} >> {i_off, 3'b000});
    assign w_sext = ~i_dmctrl[2];

    always_comb begin
        case (i_dmctrl[1:0])
            2'b00:   o_rdata = {{24{w_sext & w_raw[7]}},  w_raw[7:0]};
            2'b01:   o_rdata = {{16{w_sext & w_raw[15]}}, w_raw[15:0]};
            default: o_rdata = w_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, split into one or two word beats.
// Aligned access returns 3 cycles after accept (split +2); beats hold until mem_gnt.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W           = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_dmctrl,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;
    logic              r_we;
    logic [2:0]        r_dmctrl;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata0;
    logic [31:0]       r_rdata1;
    logic              r_err;

    logic [1:0]        w_off;
    logic              w_cross;
    logic              w_req_err;
    logic [7:0]        w_be8;
    logic [63:0]       w_wdata64;
    logic [ADDR_W-1:0] w_word0;
    logic [ADDR_W-1:0] w_word1;
    logic [31:0]       w_load_data;

    assign w_off     = r_addr[1:0];
    assign w_cross   = crosses_word(r_addr[1:0], r_dmctrl);
    assign w_req_err = dmctrl_illegal(req_dmctrl) ||
                       (crosses_word(req_addr[1:0], req_dmctrl) && !SPLIT_MISALIGNED);
    // Lanes and data are shifted as a 64-bit window; the upper half feeds the second beat.
    assign w_be8     = {4'b0000, size_mask(r_dmctrl)} << w_off;
    assign w_wdata64 = {32'h0, r_wdata} << {w_off, 3'b000};
    assign w_word0   = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_word1   = w_word0 + ADDR_W'(4);

    lsu_load_align u_load_align (
        .i_rdata1 (r_rdata1),
        .i_rdata0 (r_rdata0),
        .i_off    (w_off),
        .i_dmctrl (r_dmctrl),
        .o_rdata  (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_we     <= 1'b0;
            r_dmctrl <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_rdata0 <= 32'h0;
            r_rdata1 <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && req_valid) begin
                r_we     <= req_we;
                r_dmctrl <= req_dmctrl;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_err    <= w_req_err;
                r_rdata0 <= 32'h0;
                r_rdata1 <= 32'h0;
            end
            if (r_state == ST_WAIT0 && mem_rvalid) r_rdata0 <= mem_rdata;
            if (r_state == ST_WAIT1 && mem_rvalid) r_rdata1 <= mem_rdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_be      = 4'b0000;
        mem_wdata   = 32'h0;
        resp_valid  = 1'b0;
        resp_rdata  = 32'h0;
        resp_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = w_req_err ? ST_RESP : ST_ISSUE0;
            end
            ST_ISSUE0: begin
                mem_req   = 1'b1;
                mem_addr  = w_word0;
                mem_we    = r_we;
                mem_be    = w_be8[3:0];
                mem_wdata = w_wdata64[31:0];
                if (mem_gnt) w_state_nxt = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (mem_rvalid) w_state_nxt = w_cross ? ST_ISSUE1 : ST_RESP;
            end
            ST_ISSUE1: begin
                mem_req   = 1'b1;
                mem_addr  = w_word1;
                mem_we    = r_we;
                mem_be    = w_be8[7:4];
                mem_wdata = w_wdata64[63:32];
                if (mem_gnt) w_state_nxt = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (mem_rvalid) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid  = 1'b1;
                resp_err    = r_err;
                resp_rdata  = (r_err || r_we) ? 32'h0 : w_load_data;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized traffic against a
// byte-level reference model, mid-transaction reset, and a no-split instance.
module tb_load_store_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_dmctrl;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        ns_req_valid, ns_req_ready, ns_req_we;
    logic [2:0]  ns_req_dmctrl;
    logic [31:0] ns_req_addr, ns_req_wdata;
    logic        ns_resp_valid, ns_resp_err;
    logic [31:0] ns_resp_rdata;
    logic        ns_mem_req, ns_mem_gnt, ns_mem_we, ns_mem_rvalid;
    logic [31:0] ns_mem_addr, ns_mem_wdata, ns_mem_rdata;
    logic [3:0]  ns_mem_be;

    load_store_unit #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_dmctrl(req_dmctrl), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) u_ns (
        .clk(clk), .rst_n(rst_n),
        .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_we(ns_req_we),
        .req_dmctrl(ns_req_dmctrl), .req_addr(ns_req_addr), .req_wdata(ns_req_wdata),
        .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata), .resp_err(ns_resp_err),
        .mem_req(ns_mem_req), .mem_gnt(ns_mem_gnt), .mem_addr(ns_mem_addr), .mem_we(ns_mem_we),
        .mem_be(ns_mem_be), .mem_wdata(ns_mem_wdata), .mem_rvalid(ns_mem_rvalid),
        .mem_rdata(ns_mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    int          obs_nb, obs_lat, obs_unstable;
    logic        obs_got, obs_err, obs_pulse_ok;
    logic [31:0] obs_rdata;
    logic [31:0] obs_addr[4];
    logic [31:0] obs_wd[4];
    logic [3:0]  obs_be[4];
    logic        obs_we[4];

    int          exp_nb;
    logic        exp_err, exp_we;
    logic [31:0] exp_rdata;
    logic [31:0] exp_addr[2];
    logic [31:0] exp_wd[2];
    logic [3:0]  exp_be[2];

    typedef struct {
        logic        we;
        logic [2:0]  dm;
        logic [31:0] addr, wdata, rd0, rd1;
        logic        err;
        int          nb;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: the access is a run of bytes starting at addr; each beat lane carries
    // the request byte that lands on it after shifting by the offset.
    task automatic model(input logic we, input logic [2:0] dm, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd0,
                         input logic [31:0] rd1, input bit split);
        int          size, off, pos;
        logic [31:0] fw, lw, v;
        logic [7:0]  win[8];
        off  = int'(addr[1:0]);
        size = (dm[1:0] == 2'b00) ? 1 : (dm[1:0] == 2'b01) ? 2 : 4;
        fw   = addr & ~32'h3;
        lw   = (addr + 32'(size - 1)) & ~32'h3;
        exp_we = we; exp_err = 1'b0; exp_nb = 0; exp_rdata = 32'h0;
        for (int b = 0; b < 2; b++) begin
            exp_addr[b] = 32'h0; exp_wd[b] = 32'h0; exp_be[b] = 4'h0;
        end
        if (dm == 3'b011 || dm == 3'b110 || dm == 3'b111 || (fw != lw && !split)) begin
            exp_err = 1'b1;
        end else begin
            exp_nb = (fw != lw) ? 2 : 1;
            for (int b = 0; b < 2; b++) begin
                exp_addr[b] = fw + 32'(4 * b);
                for (int lane = 0; lane < 4; lane++) begin
                    pos = 4 * b + lane - off;
                    if (pos >= 0 && pos < 4) begin
                        exp_wd[b][8*lane +: 8] = wdata[8*pos +: 8];
                        if (pos < size) exp_be[b][lane] = 1'b1;
                    end
                end
            end
            if (!we) begin
                for (int k = 0; k < 8; k++)
                    win[k] = (k < 4) ? rd0[8*k +: 8] : ((exp_nb == 2) ? rd1[8*(k-4) +: 8] : 8'h00);
                v = 32'h0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = win[off + i];
                if (!dm[2] && size < 4 && v[8*size-1])
                    for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
                exp_rdata = v;
            end
        end
    endtask

    task automatic run_txn(input logic we, input logic [2:0] dm, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd0,
                           input logic [31:0] rd1, input int gnt_dly, input int rv_dly);
        int   waitc, rv_cnt;
        logic in_beat, rv_pend;
        @(negedge clk);
        obs_nb = 0; obs_unstable = 0; obs_got = 1'b0; obs_err = 1'b0;
        obs_rdata = 32'h0; obs_lat = -1; obs_pulse_ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_dmctrl = dm; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_dmctrl = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        in_beat = 1'b0; rv_pend = 1'b0; waitc = 0; rv_cnt = 0;
        for (int cyc = 1; cyc <= 80 && !obs_got; cyc++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (resp_valid) begin
                obs_got = 1'b1; obs_lat = cyc; obs_err = resp_err;
                obs_rdata = resp_rdata; obs_pulse_ok = !req_ready;
            end else if (mem_req) begin
                if (obs_nb < 4) begin
                    if (!in_beat) begin
                        obs_addr[obs_nb] = mem_addr; obs_be[obs_nb] = mem_be;
                        obs_wd[obs_nb] = mem_wdata; obs_we[obs_nb] = mem_we;
                        in_beat = 1'b1; waitc = 0;
                    end else if (mem_addr !== obs_addr[obs_nb] || mem_be !== obs_be[obs_nb] ||
                                 mem_wdata !== obs_wd[obs_nb] || mem_we !== obs_we[obs_nb]) begin
                        obs_unstable++;
                    end
                end
                mem_rvalid = 1'($urandom);
                if (waitc == gnt_dly) begin
                    mem_gnt = 1'b1; in_beat = 1'b0; obs_nb++; rv_pend = 1'b1; rv_cnt = rv_dly;
                end else begin
                    waitc++;
                end
            end else if (rv_pend) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = (obs_nb <= 1) ? rd0 : rd1; rv_pend = 1'b0;
                end
            end
            if (!obs_got) @(negedge clk);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (obs_got) begin
            @(negedge clk);
            obs_pulse_ok = obs_pulse_ok && !resp_valid && req_ready;
        end
    endtask

    task automatic compare(input string tag, input int exp_lat);
        chk({tag, " resp_seen"}, 32'(obs_got), 32'd1);
        chk({tag, " err"}, 32'(obs_err), 32'(exp_err));
        chk({tag, " rdata"}, obs_rdata, exp_rdata);
        chk({tag, " beats"}, 32'(obs_nb), 32'(exp_nb));
        if (exp_lat > 0) chk({tag, " latency"}, 32'(obs_lat), 32'(exp_lat));
        for (int b = 0; b < exp_nb && b < obs_nb; b++) begin
            chk($sformatf("%s beat%0d addr", tag, b), obs_addr[b], exp_addr[b]);
            chk($sformatf("%s beat%0d be", tag, b), 32'(obs_be[b]), 32'(exp_be[b]));
            chk($sformatf("%s beat%0d wdata", tag, b), obs_wd[b], exp_wd[b]);
            chk($sformatf("%s beat%0d we", tag, b), 32'(obs_we[b]), 32'(exp_we));
        end
        chk({tag, " beat_stable"}, 32'(obs_unstable), 32'd0);
        chk({tag, " one_cycle_resp"}, 32'(obs_pulse_ok), 32'd1);
    endtask

    task automatic load_vec(input vec_t v);
        exp_we = v.we; exp_err = v.err; exp_nb = v.nb; exp_rdata = v.rdata;
        exp_addr[0] = v.a0; exp_be[0] = v.be0; exp_wd[0] = v.wd0;
        exp_addr[1] = v.a1; exp_be[1] = v.be1; exp_wd[1] = v.wd1;
    endtask

    task automatic run_ns(input string tag, input logic [2:0] dm, input logic [31:0] addr);
        logic saw_req, got, err;
        logic [31:0] rdata;
        int lat;
        saw_req = 1'b0; got = 1'b0; err = 1'b0; rdata = 32'h0; lat = -1;
        @(negedge clk);
        ns_req_valid = 1'b1; ns_req_we = 1'b0; ns_req_dmctrl = dm; ns_req_addr = addr;
        ns_req_wdata = 32'h0;
        @(negedge clk);
        ns_req_valid = 1'b0;
        for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
            if (ns_mem_req) saw_req = 1'b1;
            if (ns_resp_valid) begin
                got = 1'b1; err = ns_resp_err; rdata = ns_resp_rdata; lat = cyc;
            end else begin
                @(negedge clk);
            end
        end
        chk({tag, " resp_seen"}, 32'(got), 32'd1);
        chk({tag, " no_mem_req"}, 32'(saw_req), 32'd0);
        chk({tag, " err"}, 32'(err), 32'd1);
        chk({tag, " rdata"}, rdata, 32'h0);
        chk({tag, " latency"}, 32'(lat), 32'd1);
    endtask

    initial begin
        logic [2:0]  dm;
        logic [31:0] addr;
        int          resp_seen, req_seen;

        vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0,
                     1'b0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0, 32'h0, 3};
        vecs[1]  = '{1'b0, 3'b000, 32'h203, 32'h0, 32'h80112233, 32'h0,
                     1'b0, 1, 32'h200, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFFFF80, 3};
        vecs[2]  = '{1'b0, 3'b100, 32'h203, 32'h0, 32'h80112233, 32'h0,
                     1'b0, 1, 32'h200, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00000080, 3};
        vecs[3]  = '{1'b1, 3'b001, 32'h00F, 32'h0000ABCD, 32'h0, 32'h0,
                     1'b0, 2, 32'h00C, 4'h8, 32'hCD000000, 32'h010, 4'h1, 32'h000000AB, 32'h0, 5};
        vecs[4]  = '{1'b0, 3'b010, 32'h006, 32'h0, 32'h44332211, 32'h88776655,
                     1'b0, 2, 32'h004, 4'hC, 32'h0, 32'h008, 4'h3, 32'h0, 32'h66554433, 5};
        vecs[5]  = '{1'b0, 3'b011, 32'h040, 32'h0, 32'h0, 32'h0,
                     1'b1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1};
        vecs[6]  = '{1'b0, 3'b001, 32'h002, 32'h0, 32'h80017FFF, 32'h0,
                     1'b0, 1, 32'h000, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF8001, 3};
        vecs[7]  = '{1'b0, 3'b101, 32'h002, 32'h0, 32'h80017FFF, 32'h0,
                     1'b0, 1, 32'h000, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00008001, 3};
        vecs[8]  = '{1'b1, 3'b100, 32'h101, 32'h12345678, 32'h0, 32'h0,
                     1'b0, 1, 32'h100, 4'h2, 32'h34567800, 32'h0, 4'h0, 32'h0, 32'h0, 3};
        vecs[9]  = '{1'b1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4, 32'h0, 32'h0,
                     1'b0, 2, 32'hFFFFFFFC, 4'hC, 32'hC3D40000, 32'h0, 4'h3, 32'h0000A1B2, 32'h0, 5};
        vecs[10] = '{1'b1, 3'b111, 32'h080, 32'h55, 32'h0, 32'h0,
                     1'b1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1};
        vecs[11] = '{1'b0, 3'b010, 32'h300, 32'h0, 32'h7FFFFFFF, 32'h0,
                     1'b0, 1, 32'h300, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'h7FFFFFFF, 3};

        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_dmctrl = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        ns_req_valid = 1'b0; ns_req_we = 1'b0; ns_req_dmctrl = 3'b000;
        ns_req_addr = 32'h0; ns_req_wdata = 32'h0;
        ns_mem_gnt = 1'b1; ns_mem_rvalid = 1'b0; ns_mem_rdata = 32'h0;

        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset ctrl_outs", 32'({mem_req, mem_we, mem_be, resp_valid, resp_err}), 32'd0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset ns_req_ready", 32'(ns_req_ready), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].we, vecs[i].dm, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rd0, vecs[i].rd1, 0, 1);
            load_vec(vecs[i]);
            compare($sformatf("vec%0d", i), vecs[i].lat);
        end

        run_ns("nosplit word@006", 3'b010, 32'h006);
        run_ns("nosplit half@003", 3'b001, 32'h003);

        // Reset while the load waits in WAIT0, then a stale completion arrives.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_dmctrl = 3'b010; req_addr = 32'h500;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstseq beat issued", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rstseq req_ready", 32'(req_ready), 32'd1);
        chk("rstseq ctrl_outs", 32'({mem_req, mem_we, mem_be, resp_valid, resp_err}), 32'd0);
        chk("rstseq mem_addr", mem_addr, 32'h0);
        chk("rstseq resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        rst_n = 1'b1;
        resp_seen = 0; req_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (resp_valid) resp_seen++;
            if (mem_req) req_seen++;
        end
        chk("rstseq no_resp", 32'(resp_seen), 32'd0);
        chk("rstseq no_mem_req", 32'(req_seen), 32'd0);
        run_txn(vecs[0].we, vecs[0].dm, vecs[0].addr, vecs[0].wdata, vecs[0].rd0, vecs[0].rd1, 0, 1);
        load_vec(vecs[0]);
        compare("after_reset", vecs[0].lat);

        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 9))
                0:       dm = 3'b011;
                1:       dm = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b111;
                2, 3:    dm = 3'b000;
                4:       dm = 3'b100;
                5, 6:    dm = 3'b001;
                7:       dm = 3'b101;
                default: dm = 3'b010;
            endcase
            addr = $urandom;
            if (t % 16 == 0) addr = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
            req_we = 1'($urandom);
            begin
                logic        we;
                logic [31:0] wd, r0, r1;
                we = 1'($urandom); wd = $urandom; r0 = $urandom; r1 = $urandom;
                model(we, dm, addr, wd, r0, r1, 1'b1);
                run_txn(we, dm, addr, wd, r0, r1, $urandom_range(0, 3), $urandom_range(1, 3));
                compare($sformatf("rnd%0d", t), -1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
